// File: rtl/neuron_acc_seq.sv
`default_nettype none
// ============================================================================
// Module   : neuron_acc_seq
// Purpose  : Sequences an external sign-magnitude adder to accumulate
//            N_INPUTS weighted products for one neuron. The finished sum is
//            presented on a valid/ready output port.
// Revision : 1.0  initial release
// ============================================================================
module neuron_acc_seq #(
  parameter int W        = 23,
  parameter int N_INPUTS = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  output logic [CNT_W-1:0] add_cnt,
  input  logic [W-1:0]     add_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             ovf,
  output logic             busy
);

  // Index of the final product of an evaluation.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;

  logic             w_hs;
  logic             w_ovf;
  logic [W-1:0]     w_res_norm;

  // A product is accepted only while accumulating.
  assign w_hs = in_valid && (state_q == S_ACCUM);

  // Lost magnitude carry: like-signed operands whose result shrank.
  assign w_ovf = (acc_q[W-1] == in_data[W-1]) && (add_res[W-2:0] < acc_q[W-2:0]);

  // Zero magnitude is always stored as +0; the adder may return -0.
  assign w_res_norm = (add_res[W-2:0] == '0) ? '0 : add_res;

  assign in_ready  = (state_q == S_ACCUM);
  assign busy      = (state_q != S_IDLE);
  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign add_cnt   = cnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: accumulator, product counter, flags and result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_hs) begin
          acc_d = w_res_norm;
          if (w_ovf) begin
            ovf_d = 1'b1;
          end
          if (cnt_q == LAST_IDX) begin
            // Counter parks on the last index so it never exceeds it.
            out_data_d  = w_res_norm;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_acc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_acc_seq
// Purpose  : Directed self-checking bench for neuron_acc_seq with a
//            behavioural sign-magnitude adder on the add_* ports.
// Revision : 1.0  initial release
// ============================================================================
module tb_neuron_acc_seq;

  localparam int W        = 23;
  localparam int N_INPUTS = 4;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic [CNT_W-1:0] add_cnt;
  logic [W-1:0]     add_res;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             ovf;
  logic             busy;

  int total = 0;
  int bad   = 0;

  neuron_acc_seq #(.W(W), .N_INPUTS(N_INPUTS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_cnt(add_cnt), .add_res(add_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Sign-magnitude adder; equal magnitudes of opposite sign give b's sign (-0 possible).
  function automatic logic [W-1:0] sm_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-2:0] ma, mb, m;
    logic         s;
    ma = a[W-2:0];
    mb = b[W-2:0];
    if (a[W-1] == b[W-1]) begin
      m = ma + mb;
      s = a[W-1];
    end else if (ma > mb) begin
      m = ma - mb;
      s = a[W-1];
    end else begin
      m = mb - ma;
      s = b[W-1];
    end
    return {s, m};
  endfunction

  always_comb add_res = sm_add(add_a, add_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One handshake: in_ready is already 1 in ACCUM, so one cycle suffices.
  task automatic feed(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    // Mid-accumulation reset.
    do_start();
    feed(23'h000005);
    feed(23'h000003);
    total++; if (add_cnt !== 4'd2) begin bad++; $display("FAIL mid_cnt got=%0d exp=2", add_cnt); end
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy got=%b exp=0", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL t1_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t1_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 23'h0) begin bad++; $display("FAIL t1_out_data got=%h exp=0", out_data); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL t1_ovf got=%b exp=0", ovf); end
    total++; if (add_a !== 23'h0) begin bad++; $display("FAIL t1_acc got=%h exp=0", add_a); end
    total++; if (add_cnt !== 4'd0) begin bad++; $display("FAIL t1_cnt got=%0d exp=0", add_cnt); end
  endtask

  task automatic test_basic();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL t2_idle_ready got=%b exp=0", in_ready); end
    do_start();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL t2_start_lat got=%b exp=1", in_ready); end
    feed(23'h000005);
    total++; if (add_a !== 23'h000005) begin bad++; $display("FAIL t2_acc1 got=%h exp=000005", add_a); end
    feed(23'h400003);
    total++; if (add_a !== 23'h000002) begin bad++; $display("FAIL t2_acc2 got=%h exp=000002", add_a); end
    total++; if (add_cnt !== 4'd2) begin bad++; $display("FAIL t2_cnt2 got=%0d exp=2", add_cnt); end
    feed(23'h000002);
    in_data = 23'h000007;
    #1;
    total++; if (add_b !== 23'h000007) begin bad++; $display("FAIL t2_add_b got=%h exp=000007", add_b); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t2_early_valid got=%b exp=0", out_valid); end
    feed(23'h000007);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t2_out_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 23'h00000B) begin bad++; $display("FAIL t2_out_data got=%h exp=00000b", out_data); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL t2_ovf got=%b exp=0", ovf); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL t2_done_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_idle got=%b exp=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t2_valid_clr got=%b exp=0", out_valid); end
  endtask

  task automatic test_neg_zero();
    do_start();
    feed(23'h000005);
    feed(23'h400003);
    feed(23'h000002);
    feed(23'h400004);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t3_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 23'h000000) begin bad++; $display("FAIL t3_out_data got=%h exp=000000", out_data); end
    total++; if (add_a !== 23'h000000) begin bad++; $display("FAIL t3_acc got=%h exp=000000", add_a); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] vals [4];
    vals[0] = 23'h000010;
    vals[1] = 23'h000020;
    vals[2] = 23'h400008;
    vals[3] = 23'h000001;
    do_start();
    for (int p = 0; p < 4; p++) begin
      for (int g = 0; g < 3; g++) begin
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL t4_ready_gap p=%0d got=%b exp=1", p, in_ready); end
      end
      total++; if (add_cnt !== 4'(p)) begin bad++; $display("FAIL t4_cnt_hold got=%0d exp=%0d", add_cnt, p); end
      feed(vals[p]);
    end
    for (int s = 0; s < 5; s++) begin
      total++; if (out_valid !== 1'b1 || out_data !== 23'h000029) begin bad++; $display("FAIL t4_stall s=%0d got=%b/%h exp=1/000029", s, out_valid, out_data); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_idle got=%b exp=0", busy); end
  endtask

  task automatic test_overflow();
    do_start();
    feed(23'h3FFFFF);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL t5_ovf_early got=%b exp=0", ovf); end
    feed(23'h000001);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL t5_ovf_set got=%b exp=1", ovf); end
    feed(23'h000000);
    feed(23'h000000);
    total++; if (out_data !== 23'h000000) begin bad++; $display("FAIL t5_out_data got=%h exp=000000", out_data); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL t5_ovf_sticky got=%b exp=1", ovf); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL t5_ovf_idle got=%b exp=1", ovf); end
    do_start();
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL t5_ovf_clear got=%b exp=0", ovf); end
    // Finish this evaluation cleanly.
    for (int i = 0; i < N_INPUTS; i++) feed(23'h000000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    do_start();
    feed(23'h000001);
    feed(23'h000002);
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (add_cnt !== 4'd2) begin bad++; $display("FAIL t6_cnt got=%0d exp=2", add_cnt); end
    total++; if (add_a !== 23'h000003) begin bad++; $display("FAIL t6_acc got=%h exp=000003", add_a); end
    feed(23'h000003);
    feed(23'h000004);
    total++; if (out_data !== 23'h00000A) begin bad++; $display("FAIL t6_sum got=%h exp=00000a", out_data); end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_idle got=%b exp=0", busy); end
    tick();
    total++; if (busy !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL t6_no_restart got=%b/%b exp=0/0", busy, in_ready); end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_neg_zero();
    test_backpressure();
    test_overflow();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
